fan_tach_meter: RTL
===================

// Module: fan_tach_meter
// PURPOSE
//  Measures the frequency of an external fan tachometer pulse train (tach_in, asynchronous
//  to clk_in) by counting rising edges over a fixed gate window of clk_in cycles.
//  It is the receiving end of the divided-clock path: the clock divider generates the
//  fan timing and this block reads back the pulse rate. Results feed the fan control loop.
// PARAMETERS
//  GATE_CYCLES  100_000_000  gate window length in clk_in cycles (1 s at 100 MHz)
//  CNT_W        16           width of edge counter / freq_count output
//  FILTER_LEN   4            stable-cycle count required by glitch filter (TACH_FILTER_EN only)
// PORTS
//  clk_in      in   1      system clock, all logic on rising edge
//  rst         in   1      synchronous reset, active-high
//  enable      in   1      1 = run back-to-back gate windows; 0 = abort/idle
//  tach_in     in   1      raw tachometer pulse, asynchronous
//  freq_count  out  CNT_W  rising edges counted in last completed window
//  valid       out  1      1-cycle strobe: freq_count/stall/overflow updated
//  stall       out  1      last completed window had zero edges
//  overflow    out  1      last completed window saturated the counter
// BEHAVIOUR
//  - Reset (rst=1 at clk_in edge): state=IDLE, gate_cnt=0, edge_cnt=0, freq_count=0,
//    valid=0, stall=0, overflow=0, sync flops=0, edge-detect history=0.
//  - tach_in passes a 2-flop synchronizer, then rising-edge detect (prev=0, cur=1).
//    Sync + detect latency = 3 clk_in cycles from tach_in rise to edge pulse.
//  - FSM: IDLE -> MEASURE when enable=1 (gate_cnt=0, edge_cnt=0 on entry).
//    MEASURE: gate_cnt increments each cycle; edge pulse increments edge_cnt.
//    When gate_cnt == GATE_CYCLES-1: -> LATCH. LATCH (1 cycle): freq_count<=edge_cnt,
//    stall<=(edge_cnt==0), overflow<=sat_flag, valid<=1; clear edge_cnt/gate_cnt/sat_flag;
//    -> MEASURE if enable=1 else IDLE. Edges arriving during LATCH count in next window.
//  - Edge pulse on final MEASURE cycle (gate_cnt==GATE_CYCLES-1) is counted in the
//    current window.
//  - Saturation: edge_cnt stops at 2**CNT_W-1 and sets sat_flag; no wrap-around.
//  - enable=0 during MEASURE: abort to IDLE next cycle, partial count discarded, no valid
//    strobe; freq_count/stall/overflow hold last published values.
//  - rst mid-window overrides all: immediate return to reset values.
//  - valid is high exactly one cycle per completed window; window period = GATE_CYCLES+1.
//  - gate_cnt width = $clog2(GATE_CYCLES); GATE_CYCLES >= 2.
// CONFIGURATION
//  TACH_FILTER_EN defined: synchronized tach level is accepted only after it has been
//    stable for FILTER_LEN consecutive cycles; pulses shorter than FILTER_LEN cycles are
//    rejected; edge latency becomes 3+FILTER_LEN cycles.
//  TACH_FILTER_EN undefined: synchronizer output feeds edge detect directly; FILTER_LEN
//    unused; every synchronized rising edge counts.
// STRUCTURE
//  - Shared package fan_pkg: FSM state enum (IDLE, MEASURE, LATCH), default GATE_CYCLES
//    and CNT_W constants shared with clock divider / controller.
//  - Sub-module tach_sync_filter: synchronizer + optional filter + edge detect, outputs
//    1-cycle edge pulse. Top holds FSM, gate and edge counters, output registers.
// TESTING (bench overrides GATE_CYCLES=100, CNT_W=8, FILTER_LEN=4, clk_in 10 ns)
//  1. enable=1, tach_in square period 10 cycles -> valid every 101 cycles, freq_count=10
//     (+/-1 first window), stall=0, overflow=0.
//  2. enable=1, tach_in held 0 -> valid after window, freq_count=0, stall=1.
//  3. CNT_W=4, tach_in period 2 cycles (50 edges) -> freq_count=15, overflow=1.
//  4. enable dropped at gate_cnt=50 -> no valid strobe, outputs hold prior values;
//     re-enable -> full fresh window, next count correct.
//  5. rst pulsed mid-window -> all outputs 0 next cycle; FSM IDLE until enable.
//  6. TACH_FILTER_EN: 2-cycle glitches ignored (count 0); 6-cycle-wide pulses period 20
//     -> freq_count=5. Without macro, same glitches are counted.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared fan-control definitions: measurement FSM encoding and default timing constants,
// common to the clock divider, the tach meter and the fan controller.
package fan_pkg;

   // Defaults assume a 100 MHz system clock: a 1 s gate and a 16-bit edge count
   localparam int unsigned DEF_GATE_CYCLES = 100_000_000;
   localparam int unsigned DEF_CNT_W       = 16;
   localparam int unsigned DEF_FILTER_LEN  = 4;

   // Flops between the asynchronous tach pin and the first use of its level
   localparam int unsigned SYNC_STAGES     = 2;

   // Measurement FSM encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_LATCH   = 2'd2;

endpackage

// File: rtl/tach_sync_filter.sv
// Tach input conditioning: 2-flop synchronizer, optional stability filter
// (enabled by the TACH_FILTER_EN macro), and a registered rising-edge pulse.
module tach_sync_filter
   import fan_pkg::*;
#(
   parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
   input  logic clk_in,
   input  logic rst,
   input  logic tach_in,
   output logic edge_pulse
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   level;
   logic                   level_prev_reg;
   logic                   edge_reg;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], tach_in};
      end
   end

`ifdef TACH_FILTER_EN
   localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

   logic [FLT_W-1:0] stab_cnt_reg;
   logic             filt_reg;

   // The accepted level only moves once the synchronized input has disagreed with it
   // for FILTER_LEN consecutive cycles; any shorter excursion resets the count.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         stab_cnt_reg <= '0;
         filt_reg     <= 1'b0;
      end else if (sync_reg[SYNC_STAGES-1] == filt_reg) begin
         stab_cnt_reg <= '0;
      end else if (stab_cnt_reg == FLT_W'(FILTER_LEN - 1)) begin
         stab_cnt_reg <= '0;
         filt_reg     <= sync_reg[SYNC_STAGES-1];
      end else begin
         stab_cnt_reg <= stab_cnt_reg + 1'b1;
      end
   end

   assign level = filt_reg;
`else
   // Without the filter every synchronized rising edge is used; FILTER_LEN has no effect.
   logic unused_filter_len;
   assign unused_filter_len = (FILTER_LEN != 0);
   assign level             = sync_reg[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk_in) begin
      if (rst) begin
         level_prev_reg <= 1'b0;
         edge_reg       <= 1'b0;
      end else begin
         level_prev_reg <= level;
         edge_reg       <= level & ~level_prev_reg;
      end
   end

   assign edge_pulse = edge_reg;

endmodule

// File: rtl/fan_tach_meter.sv
// Fan tachometer frequency meter: counts conditioned tach rising edges over back-to-back
// gate windows of GATE_CYCLES clocks. Optional glitch filter selected by TACH_FILTER_EN.
module fan_tach_meter
   import fan_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             enable,
   input  logic             tach_in,
   output logic [CNT_W-1:0] freq_count,
   output logic             valid,
   output logic             stall,
   output logic             overflow
);

   localparam int unsigned      GATE_W    = $clog2(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   logic              edge_pulse;

   logic [1:0]        state_reg,      state_next;
   logic [GATE_W-1:0] gate_cnt_reg,   gate_cnt_next;
   logic [CNT_W-1:0]  edge_cnt_reg,   edge_cnt_next;
   logic              sat_reg,        sat_next;
   logic [CNT_W-1:0]  freq_count_reg, freq_count_next;
   logic              valid_reg,      valid_next;
   logic              stall_reg,      stall_next;
   logic              overflow_reg,   overflow_next;

   tach_sync_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_sync_filter (
      .clk_in     (clk_in),
      .rst        (rst),
      .tach_in    (tach_in),
      .edge_pulse (edge_pulse)
   );

   always_comb begin
      state_next      = state_reg;
      gate_cnt_next   = gate_cnt_reg;
      edge_cnt_next   = edge_cnt_reg;
      sat_next        = sat_reg;
      freq_count_next = freq_count_reg;
      valid_next      = 1'b0;
      stall_next      = stall_reg;
      overflow_next   = overflow_reg;

      case (state_reg)
         ST_IDLE: begin
            if (enable) begin
               state_next    = ST_MEASURE;
               gate_cnt_next = '0;
               edge_cnt_next = '0;
               sat_next      = 1'b0;
            end
         end

         ST_MEASURE: begin
            if (!enable) begin
               // Abort: the partial window is dropped and published results stay put
               state_next    = ST_IDLE;
               gate_cnt_next = '0;
               edge_cnt_next = '0;
               sat_next      = 1'b0;
            end else begin
               if (edge_pulse) begin
                  if (edge_cnt_reg != CNT_MAX) begin
                     edge_cnt_next = edge_cnt_reg + 1'b1;
                  end
                  if (edge_cnt_reg >= CNT_MAX - 1'b1) begin
                     sat_next = 1'b1;
                  end
               end
               if (gate_cnt_reg == GATE_LAST) begin
                  state_next = ST_LATCH;
               end else begin
                  gate_cnt_next = gate_cnt_reg + 1'b1;
               end
            end
         end

         ST_LATCH: begin
            freq_count_next = edge_cnt_reg;
            stall_next      = (edge_cnt_reg == '0);
            overflow_next   = sat_reg;
            valid_next      = 1'b1;
            gate_cnt_next   = '0;
            // An edge seen while publishing belongs to the window that starts now
            edge_cnt_next   = CNT_W'(edge_pulse);
            sat_next        = edge_pulse && (CNT_W == 1);
            state_next      = enable ? ST_MEASURE : ST_IDLE;
         end

         default: begin
            state_next    = ST_IDLE;
            gate_cnt_next = '0;
            edge_cnt_next = '0;
            sat_next      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         gate_cnt_reg   <= '0;
         edge_cnt_reg   <= '0;
         sat_reg        <= 1'b0;
         freq_count_reg <= '0;
         valid_reg      <= 1'b0;
         stall_reg      <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         gate_cnt_reg   <= gate_cnt_next;
         edge_cnt_reg   <= edge_cnt_next;
         sat_reg        <= sat_next;
         freq_count_reg <= freq_count_next;
         valid_reg      <= valid_next;
         stall_reg      <= stall_next;
         overflow_reg   <= overflow_next;
      end
   end

   assign freq_count = freq_count_reg;
   assign valid      = valid_reg;
   assign stall      = stall_reg;
   assign overflow   = overflow_reg;

endmodule
